// File: rtl/cmd_queue_if.sv
// Host-side command fields, master-side load bus and queue status for cmd_queue.
interface cmd_queue_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          PUSH;
  logic [47:0]   IN_DDS_freq;
  logic [47:0]   IN_DDS_delta_freq;
  logic [31:0]   IN_DDS_delta_rate;
  logic [63:0]   IN_TIME_START;
  logic [15:0]   IN_N_impuls;
  logic [1:0]    IN_TYPE_impulse;
  logic [31:0]   IN_Interval_Ti;
  logic [31:0]   IN_Interval_Tp;
  logic [31:0]   IN_Tblank1;
  logic [31:0]   IN_Tblank2;
  logic          FLUSH;
  logic [63:0]   TIME;
  logic          TIME_VALID;
  logic          REQ_COMMAND;

  logic          WR_DATA;
  logic [47:0]   MEM_DDS_freq;
  logic [47:0]   MEM_DDS_delta_freq;
  logic [31:0]   MEM_DDS_delta_rate;
  logic [63:0]   MEM_TIME_START;
  logic [15:0]   MEM_N_impuls;
  logic [1:0]    MEM_TYPE_impulse;
  logic [31:0]   MEM_Interval_Ti;
  logic [31:0]   MEM_Interval_Tp;
  logic [31:0]   MEM_Tblank1;
  logic [31:0]   MEM_Tblank2;
  logic [AW:0]   LEVEL;
  logic          EMPTY;
  logic          FULL;
  logic          LOADED;
  logic [15:0]   OVF_CNT;
  logic [15:0]   STALE_CNT;

  modport master (
    output PUSH, IN_DDS_freq, IN_DDS_delta_freq, IN_DDS_delta_rate, IN_TIME_START,
           IN_N_impuls, IN_TYPE_impulse, IN_Interval_Ti, IN_Interval_Tp, IN_Tblank1,
           IN_Tblank2, FLUSH, TIME, TIME_VALID, REQ_COMMAND,
    input  WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
           MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1,
           MEM_Tblank2, LEVEL, EMPTY, FULL, LOADED, OVF_CNT, STALE_CNT
  );

  modport slave (
    input  PUSH, IN_DDS_freq, IN_DDS_delta_freq, IN_DDS_delta_rate, IN_TIME_START,
           IN_N_impuls, IN_TYPE_impulse, IN_Interval_Ti, IN_Interval_Tp, IN_Tblank1,
           IN_Tblank2, FLUSH, TIME, TIME_VALID, REQ_COMMAND,
    output WR_DATA, MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
           MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1,
           MEM_Tblank2, LEVEL, EMPTY, FULL, LOADED, OVF_CNT, STALE_CNT
  );
endinterface

// File: rtl/cmd_queue.sv
// Burst-command queue keeping the pulse-burst master loaded; late commands are dropped.
module cmd_queue #(
  parameter int          DEPTH = 16,
  parameter int          AW    = $clog2(DEPTH),
  parameter int unsigned LEAD  = 48
) (
  input logic           CLK,
  input logic           RESET,
  cmd_queue_if.slave    bus
);
  localparam int W = 338;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] LOAD  = 2'd3;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_data;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [1:0]    state;
  logic          req_d, loaded;
  logic [15:0]   ovf_cnt, stale_cnt;
  logic          full, empty, push_ok, pop, req_rise, late;

  logic [47:0] f_freq, f_dfreq;
  logic [31:0] f_drate;
  logic [63:0] f_time;
  logic [15:0] f_n;
  logic [1:0]  f_type;
  logic [31:0] f_ti, f_tp, f_tb1, f_tb2;

  assign wr_data = {bus.IN_DDS_freq, bus.IN_DDS_delta_freq, bus.IN_DDS_delta_rate,
                    bus.IN_TIME_START, bus.IN_N_impuls, bus.IN_TYPE_impulse,
                    bus.IN_Interval_Ti, bus.IN_Interval_Tp, bus.IN_Tblank1, bus.IN_Tblank2};
  assign {f_freq, f_dfreq, f_drate, f_time, f_n, f_type, f_ti, f_tp, f_tb1, f_tb2} = rd_data;

  always_comb begin
    full     = (level == (AW+1)'(DEPTH));
    empty    = (level == '0);
    push_ok  = bus.PUSH && !full && !bus.FLUSH;
    pop      = (state == CHECK) && !bus.FLUSH;
    req_rise = bus.REQ_COMMAND && !req_d;
    late     = !(f_time > (bus.TIME + 64'(LEAD)));
  end

  assign bus.LEVEL     = level;
  assign bus.EMPTY     = empty;
  assign bus.FULL      = full;
  assign bus.LOADED    = loaded;
  assign bus.OVF_CNT   = ovf_cnt;
  assign bus.STALE_CNT = stale_cnt;

  always_ff @(posedge CLK) begin
    if (!RESET && push_ok) mem[wr_ptr] <= wr_data;
    if (state == READ) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      state     <= IDLE;
      req_d     <= 1'b0;
      loaded    <= 1'b0;
      ovf_cnt   <= '0;
      stale_cnt <= '0;
      bus.WR_DATA            <= 1'b0;
      bus.MEM_DDS_freq       <= '0;
      bus.MEM_DDS_delta_freq <= '0;
      bus.MEM_DDS_delta_rate <= '0;
      bus.MEM_TIME_START     <= '1;
      bus.MEM_N_impuls       <= '0;
      bus.MEM_TYPE_impulse   <= '0;
      bus.MEM_Interval_Ti    <= '0;
      bus.MEM_Interval_Tp    <= '0;
      bus.MEM_Tblank1        <= '0;
      bus.MEM_Tblank2        <= '0;
    end else begin
      req_d       <= bus.REQ_COMMAND;
      bus.WR_DATA <= 1'b0;
      if (bus.FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        loaded <= 1'b0;
        state  <= IDLE;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (bus.PUSH && full && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
        level <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        if (req_rise) loaded <= 1'b0;
        case (state)
          IDLE:  if (!empty && !loaded && bus.TIME_VALID) state <= READ;
          READ:  state <= CHECK;
          CHECK: begin
            if (late) begin
              if (stale_cnt != '1) stale_cnt <= stale_cnt + 16'd1;
              state <= IDLE;
            end else begin
              // Fields and strobe are registered on entry to LOAD so WR_DATA is
              // high during LOAD with the fields already stable.
              bus.MEM_DDS_freq       <= f_freq;
              bus.MEM_DDS_delta_freq <= f_dfreq;
              bus.MEM_DDS_delta_rate <= f_drate;
              bus.MEM_TIME_START     <= f_time;
              bus.MEM_N_impuls       <= f_n;
              bus.MEM_TYPE_impulse   <= f_type;
              bus.MEM_Interval_Ti    <= f_ti;
              bus.MEM_Interval_Tp    <= f_tp;
              bus.MEM_Tblank1        <= f_tb1;
              bus.MEM_Tblank2        <= f_tb2;
              bus.WR_DATA            <= 1'b1;
              loaded                 <= 1'b1;
              state                  <= LOAD;
            end
          end
          LOAD:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_queue.sv
// Directed self-checking bench for cmd_queue with a 4-entry queue.
module tb_cmd_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_queue_if #(.DEPTH(4)) bus ();
  cmd_queue #(.DEPTH(4), .LEAD(48)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [63:0] t);
    bus.IN_TIME_START     = t;
    bus.IN_DDS_freq       = 48'hA000_0000_0000 | 48'(t);
    bus.IN_DDS_delta_freq = 48'(t) + 48'd3;
    bus.IN_DDS_delta_rate = 32'(t) + 32'd5;
    bus.IN_N_impuls       = 16'(t) ^ 16'h5A5A;
    bus.IN_TYPE_impulse   = 2'(t / 1000);
    bus.IN_Interval_Ti    = 32'(t) + 32'd11;
    bus.IN_Interval_Tp    = 32'(t) + 32'd13;
    bus.IN_Tblank1        = 32'(t) + 32'd17;
    bus.IN_Tblank2        = 32'(t) + 32'd19;
  endtask

  task automatic push(input logic [63:0] t);
    set_fields(t);
    bus.PUSH = 1'b1;
    tick();
    bus.PUSH = 1'b0;
  endtask

  task automatic wait_wr(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.WR_DATA && cnt < max);
  endtask

  task automatic count_wr(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      tick();
      if (bus.WR_DATA) cnt++;
    end
  endtask

  initial begin
    bus.PUSH = 1'b0; bus.FLUSH = 1'b0; bus.REQ_COMMAND = 1'b0;
    bus.TIME = 64'd1000; bus.TIME_VALID = 1'b1;
    set_fields(64'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_empty", bus.EMPTY, 1'b1);
    chk("rst_full", bus.FULL, 1'b0);
    chk("rst_level", bus.LEVEL, 0);
    chk("rst_loaded", bus.LOADED, 1'b0);
    chk("rst_wr", bus.WR_DATA, 1'b0);
    chk("rst_mem_time", bus.MEM_TIME_START, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mem_freq", bus.MEM_DDS_freq, 0);
    chk("rst_ovf", bus.OVF_CNT, 0);
    chk("rst_stale", bus.STALE_CNT, 0);

    // Initial load: WR_DATA 3 cycles after EMPTY falls
    push(64'd5000);
    chk("load_empty", bus.EMPTY, 1'b0);
    chk("load_level1", bus.LEVEL, 1);
    wait_wr(10, n);
    chk("load_latency", n, 3);
    chk("load_time", bus.MEM_TIME_START, 64'd5000);
    chk("load_nimp", bus.MEM_N_impuls, 16'd5000 ^ 16'h5A5A);
    chk("load_tb2", bus.MEM_Tblank2, 32'd5019);
    chk("load_freq", bus.MEM_DDS_freq, 48'hA000_0000_1388);
    chk("load_loaded", bus.LOADED, 1'b1);
    chk("load_level0", bus.LEVEL, 0);
    tick();
    chk("load_pulse_end", bus.WR_DATA, 1'b0);

    // Sequencing B then C, one load per REQ_COMMAND rising edge
    push(64'd9000);
    push(64'd13000);
    count_wr(4, n);
    chk("seq_hold", n, 0);
    bus.REQ_COMMAND = 1'b1;
    wait_wr(10, n);
    chk("seq_b_lat", n, 4);
    chk("seq_b_time", bus.MEM_TIME_START, 64'd9000);
    chk("seq_b_ti", bus.MEM_Interval_Ti, 32'd9011);
    count_wr(6, n);
    chk("seq_req_high", n, 0);
    chk("seq_level", bus.LEVEL, 1);
    bus.REQ_COMMAND = 1'b0;
    tick();
    bus.REQ_COMMAND = 1'b1;
    wait_wr(10, n);
    chk("seq_c_time", bus.MEM_TIME_START, 64'd13000);
    chk("seq_c_type", bus.MEM_TYPE_impulse, 2'd1);
    bus.REQ_COMMAND = 1'b0;
    tick();

    // Stale drop: 10020 inside LEAD, 10048 exactly at TIME+LEAD, 20000 issued
    bus.TIME = 64'd10000;
    push(64'd10020);
    push(64'd10048);
    push(64'd20000);
    bus.REQ_COMMAND = 1'b1;
    wait_wr(30, n);
    chk("stale_lat", n, 10);
    chk("stale_time", bus.MEM_TIME_START, 64'd20000);
    chk("stale_cnt", bus.STALE_CNT, 2);
    chk("stale_level", bus.LEVEL, 0);
    bus.REQ_COMMAND = 1'b0;
    tick();

    // Overflow with LOADED=1
    for (int i = 0; i < 6; i++) push(64'd30000 + 64'(i) * 64'd1000);
    chk("ovf_level", bus.LEVEL, 4);
    chk("ovf_full", bus.FULL, 1'b1);
    chk("ovf_cnt", bus.OVF_CNT, 2);
    bus.REQ_COMMAND = 1'b1;
    tick(); tick(); tick();
    set_fields(64'd36000);
    bus.PUSH = 1'b1;
    tick();
    bus.PUSH = 1'b0;
    chk("ovf_pop_wr", bus.WR_DATA, 1'b1);
    chk("ovf_pop_time", bus.MEM_TIME_START, 64'd30000);
    chk("ovf_pop_level", bus.LEVEL, 3);
    chk("ovf_pop_cnt", bus.OVF_CNT, 3);
    chk("ovf_pop_full", bus.FULL, 1'b0);
    bus.REQ_COMMAND = 1'b0;
    tick();

    // FLUSH (with a concurrent PUSH) during READ
    bus.REQ_COMMAND = 1'b1;
    tick(); tick();
    set_fields(64'd37000);
    bus.PUSH = 1'b1;
    bus.FLUSH = 1'b1;
    tick();
    bus.PUSH = 1'b0;
    bus.FLUSH = 1'b0;
    chk("flush_level", bus.LEVEL, 0);
    chk("flush_empty", bus.EMPTY, 1'b1);
    chk("flush_loaded", bus.LOADED, 1'b0);
    count_wr(6, n);
    chk("flush_no_wr", n, 0);
    chk("flush_mem_kept", bus.MEM_TIME_START, 64'd30000);
    chk("flush_ovf_kept", bus.OVF_CNT, 3);
    chk("flush_stale_kept", bus.STALE_CNT, 2);

    // TIME_VALID low holds the queue in IDLE
    bus.TIME_VALID = 1'b0;
    push(64'd40000);
    count_wr(5, n);
    chk("tv_no_wr", n, 0);
    chk("tv_level", bus.LEVEL, 1);
    bus.TIME_VALID = 1'b1;
    wait_wr(10, n);
    chk("tv_latency", n, 3);
    chk("tv_time", bus.MEM_TIME_START, 64'd40000);
    chk("tv_loaded", bus.LOADED, 1'b1);

    // RESET during CHECK
    bus.REQ_COMMAND = 1'b0;
    tick();
    push(64'd50000);
    bus.REQ_COMMAND = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_mem_time", bus.MEM_TIME_START, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst2_ovf", bus.OVF_CNT, 0);
    chk("rst2_stale", bus.STALE_CNT, 0);
    chk("rst2_empty", bus.EMPTY, 1'b1);
    chk("rst2_loaded", bus.LOADED, 1'b0);
    chk("rst2_wr", bus.WR_DATA, 1'b0);
    count_wr(5, n);
    chk("rst2_no_wr", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end
endmodule
